// File: rtl/sram_bytemask_ctrl.sv
// Byte-maskable SRAM with one write and one read port, configurable read latency,
// a selectable same-address collision policy and a zero-fill sequencer.
module sram_bytemask_ctrl #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 10,
    parameter int RD_LAT  = 1,
    parameter int RW_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  csb,
    input  logic                  wsb,
    input  logic [DATA_W/8-1:0]   bytemask,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [ADDR_W-1:0]     raddr,
    input  logic                  clr,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rvalid,
    output logic                  init_busy
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              init_busy_q, init_busy_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] pipe_data_q, pipe_data_d;
    logic              pipe_valid_q, pipe_valid_d;

    logic              in_idle;
    logic              rd_fire;
    logic              wr_fire;
    logic              rd_in_range;
    logic              collide;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] merged;

    assign in_idle     = (state_q == S_IDLE);
    assign rd_fire     = in_idle && !csb;
    assign wr_fire     = in_idle && !csb && !wsb && ({1'b0, waddr} < DEPTH_X);
    assign rd_in_range = ({1'b0, raddr} < DEPTH_X);
    assign rd_word     = rd_in_range ? mem[raddr[IDX_W-1:0]] : '0;
    assign collide     = (RW_MODE == 1) && wr_fire && (waddr == raddr);

    // Write-through merge: only lanes actually being written replace the old bytes.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            assign merged[gi*8 +: 8] = (collide && bytemask[gi]) ? wdata[gi*8 +: 8]
                                                                : rd_word[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        clr_addr_d   = clr_addr_q;
        init_busy_d  = init_busy_q;
        pipe_data_d  = pipe_data_q;
        pipe_valid_d = 1'b0;
        rvalid_d     = 1'b0;
        rdata_d      = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (clr) begin
                    state_d     = S_CLEAR;
                    clr_addr_d  = '0;
                    init_busy_d = 1'b1;
                end
            end
            default: begin
                if (clr_addr_q == LAST_ADDR) begin
                    state_d     = S_IDLE;
                    clr_addr_d  = '0;
                    init_busy_d = 1'b0;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
        endcase

        // The output stage keeps draining a read already in the pipe even once CLEAR starts.
        if (RD_LAT == 2) begin
            pipe_valid_d = rd_fire;
            if (rd_fire) begin
                pipe_data_d = merged;
            end
            rvalid_d = pipe_valid_q;
            if (pipe_valid_q) begin
                rdata_d = pipe_data_q;
            end
        end else begin
            rvalid_d = rd_fire;
            if (rd_fire) begin
                rdata_d = merged;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_CLEAR;
            clr_addr_q   <= '0;
            init_busy_q  <= 1'b1;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
            pipe_data_q  <= '0;
            pipe_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            init_busy_q  <= init_busy_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
            pipe_data_q  <= pipe_data_d;
            pipe_valid_q <= pipe_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == S_CLEAR) begin
                mem[clr_addr_q[IDX_W-1:0]] <= '0;
            end else if (wr_fire) begin
                for (int i = 0; i < NB; i++) begin
                    if (bytemask[i]) begin
                        mem[waddr[IDX_W-1:0]][i*8 +: 8] <= wdata[i*8 +: 8];
                    end
                end
            end
        end
    end

    assign rdata     = rdata_q;
    assign rvalid    = rvalid_q;
    assign init_busy = init_busy_q;

endmodule
